// File: rtl/z_alu_mc.sv
// z_alu_mc: multi-cycle MIPS execute-stage ALU.
// It runs single-cycle R/I-type operations and an iterative shift-add multu
// that writes the HI/LO registers. Results are registered.
//
// Ports:
//   clk, rst          - clock and asynchronous active-high reset
//   valid_in          - operation request, sampled only while ready_out=1
//   ready_out         - idle and able to accept a request (decoded from state)
//   a_in, b_in        - operands rs / rt
//   shamt_in          - shift amount for sll/srl/sra
//   ins_in            - instruction word (opcode [31:26], funct [5:0], imm [15:0])
//   out, zero         - registered result and (result == 0)
//   valid_out         - one-cycle pulse when out/zero update
//   hi_out, lo_out    - multiply HI/LO registers
module z_alu_mc #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic [SHAMT_W-1:0] shamt_in,
  input  logic [31:0]        ins_in,
  output logic [WIDTH-1:0]   out,
  output logic               zero,
  output logic               valid_out,
  output logic [WIDTH-1:0]   hi_out,
  output logic [WIDTH-1:0]   lo_out
);

  typedef enum logic {IDLE, MUL} state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL    = 6'h00;
  localparam logic [5:0] F_SRL    = 6'h02;
  localparam logic [5:0] F_SRA    = 6'h03;
  localparam logic [5:0] F_MFHI   = 6'h10;
  localparam logic [5:0] F_MFLO   = 6'h12;
  localparam logic [5:0] F_MULTU  = 6'h19;
  localparam logic [5:0] F_ADDU   = 6'h21;
  localparam logic [5:0] F_SUBU   = 6'h23;
  localparam logic [5:0] F_AND    = 6'h24;
  localparam logic [5:0] F_OR     = 6'h25;
  localparam logic [5:0] F_NOR    = 6'h27;
  localparam logic [5:0] F_SLT    = 6'h2A;
  localparam logic [5:0] F_SLTU   = 6'h2B;

  localparam logic [SHAMT_W-1:0] LAST_ITER = SHAMT_W'(WIDTH - 1);

  state_t             state;
  logic [SHAMT_W-1:0] cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;

  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [15:0]      imm;
  logic [WIDTH-1:0] imm_sx;
  logic [WIDTH-1:0] imm_zx;
  logic [WIDTH-1:0] res;
  logic             start_mul;
  logic             unused_ins_bits;

  assign opcode          = ins_in[31:26];
  assign funct           = ins_in[5:0];
  assign imm             = ins_in[15:0];
  assign imm_sx          = WIDTH'($signed(imm));
  assign imm_zx          = WIDTH'(imm);
  assign unused_ins_bits = ^ins_in[25:16];

  assign ready_out = (state == IDLE);

  // Unknown opcode/funct falls through with res = 0, which gives zero = 1.
  always_comb begin
    res       = '0;
    start_mul = 1'b0;
    if (opcode == OP_RTYPE) begin
      case (funct)
        F_ADDU:  res = a_in + b_in;
        F_SUBU:  res = a_in - b_in;
        F_AND:   res = a_in & b_in;
        F_OR:    res = a_in | b_in;
        F_NOR:   res = ~(a_in | b_in);
        F_SLL:   res = b_in << shamt_in;
        F_SRL:   res = b_in >> shamt_in;
        F_SRA:   res = $signed(b_in) >>> shamt_in;
        F_SLT:   res = WIDTH'($signed(a_in) < $signed(b_in));
        F_SLTU:  res = WIDTH'(a_in < b_in);
        F_MFHI:  res = hi_out;
        F_MFLO:  res = lo_out;
        F_MULTU: start_mul = 1'b1;
        default: res = '0;
      endcase
    end else begin
      case (opcode)
        OP_ADDIU, OP_LW, OP_SW: res = a_in + imm_sx;
        OP_ANDI:                res = a_in & imm_zx;
        OP_BEQ, OP_BNE:         res = a_in - b_in;
        default:                res = '0;
      endcase
    end
  end

  // One shift-add step: multiplier consumed LSB first, multiplicand shifts up.
  assign acc_nxt = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      out       <= '0;
      zero      <= 1'b0;
      valid_out <= 1'b0;
      hi_out    <= '0;
      lo_out    <= '0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            if (start_mul) begin
              mcand  <= {{WIDTH{1'b0}}, a_in};
              mplier <= b_in;
              acc    <= '0;
              cnt    <= '0;
              state  <= MUL;
            end else begin
              out       <= res;
              zero      <= (res == '0);
              valid_out <= 1'b1;
            end
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            hi_out    <= acc_nxt[2*WIDTH-1:WIDTH];
            lo_out    <= acc_nxt[WIDTH-1:0];
            out       <= acc_nxt[WIDTH-1:0];
            zero      <= (acc_nxt[WIDTH-1:0] == '0);
            valid_out <= 1'b1;
            cnt       <= '0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_z_alu_mc.sv
module tb_z_alu_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [31:0] a_in = '0, b_in = '0, ins_in = '0;
  logic [4:0]  shamt_in = '0;
  logic [31:0] out, hi_out, lo_out;
  logic        zero, valid_out;

  logic        valid_in16 = 1'b0;
  logic        ready16;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] ins16 = '0;
  logic [3:0]  shamt16 = '0;
  logic [15:0] out16, hi16, lo16;
  logic        zero16, valid16;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  z_alu_mc #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
    .a_in(a_in), .b_in(b_in), .shamt_in(shamt_in), .ins_in(ins_in),
    .out(out), .zero(zero), .valid_out(valid_out),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  z_alu_mc #(.WIDTH(16), .SHAMT_W(4)) dut16 (
    .clk(clk), .rst(rst), .valid_in(valid_in16), .ready_out(ready16),
    .a_in(a16), .b_in(b16), .shamt_in(shamt16), .ins_in(ins16),
    .out(out16), .zero(zero16), .valid_out(valid16),
    .hi_out(hi16), .lo_out(lo16)
  );

  function automatic logic [31:0] rtype(input logic [5:0] f);
    rtype = {6'h00, 20'h0, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    itype = {op, 10'h0, imm};
  endfunction

  // Presents one request for exactly one edge; returns #1 after that edge.
  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    ins_in = ins; a_in = a; b_in = b; shamt_in = sh; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (out !== 32'h0 || hi_out !== 32'h0 || lo_out !== 32'h0) begin
      failures++;
      $display("FAIL reset_regs out=%h hi=%h lo=%h required 0/0/0", out, hi_out, lo_out);
    end
    checks++;
    if (zero !== 1'b0 || valid_out !== 1'b0 || ready_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_flags zero=%b valid=%b ready=%b required 0/0/1", zero, valid_out, ready_out);
    end
    checks++;
    if (out16 !== 16'h0 || ready16 !== 1'b1 || valid16 !== 1'b0) begin
      failures++;
      $display("FAIL reset_w16 out=%h ready=%b valid=%b required 0/1/0", out16, ready16, valid16);
    end
  endtask

  task automatic test_back_to_back;
    issue(rtype(6'h21), 32'h0FB7AFF0, 32'hA00D0FF0, 5'd0);
    checks++;
    if (out !== 32'hAFC4BFE0 || zero !== 1'b0 || valid_out !== 1'b1) begin
      failures++;
      $display("FAIL addu out=%h zero=%b valid=%b required AFC4BFE0/0/1", out, zero, valid_out);
    end
    issue(rtype(6'h23), 32'h0FB7AFF0, 32'hA00D0FF0, 5'd0);
    checks++;
    if (out !== 32'h6FAAA000 || valid_out !== 1'b1 || ready_out !== 1'b1) begin
      failures++;
      $display("FAIL subu out=%h valid=%b ready=%b required 6FAAA000/1/1", out, valid_out, ready_out);
    end
    @(posedge clk); #1;
    checks++;
    if (valid_out !== 1'b0 || out !== 32'h6FAAA000) begin
      failures++;
      $display("FAIL idle_no_pulse valid=%b out=%h required 0/6FAAA000", valid_out, out);
    end
  endtask

  task automatic test_logic;
    issue(rtype(6'h24), 32'h0FB7AFF0, 32'hA00D0FF0, 5'd0);
    checks++;
    if (out !== 32'h00050FF0) begin
      failures++; $display("FAIL and out=%h required 00050FF0", out);
    end
    issue(rtype(6'h25), 32'h0FB7AFF0, 32'hA00D0FF0, 5'd0);
    checks++;
    if (out !== 32'hAFBFAFF0) begin
      failures++; $display("FAIL or out=%h required AFBFAFF0", out);
    end
    issue(rtype(6'h27), 32'h0FB7AFF0, 32'hA00D0FF0, 5'd0);
    checks++;
    if (out !== 32'h5040500F) begin
      failures++; $display("FAIL nor out=%h required 5040500F", out);
    end
  endtask

  task automatic test_shifts;
    issue(rtype(6'h00), 32'h0, 32'h0FB7AFF0, 5'd2);
    checks++;
    if (out !== 32'h3EDEBFC0) begin
      failures++; $display("FAIL sll out=%h required 3EDEBFC0", out);
    end
    issue(rtype(6'h03), 32'h0, 32'hA00D0FF0, 5'd2);
    checks++;
    if (out !== 32'hE80343FC) begin
      failures++; $display("FAIL sra out=%h required E80343FC", out);
    end
    issue(rtype(6'h02), 32'h0, 32'hA00D0FF0, 5'd2);
    checks++;
    if (out !== 32'h280343FC) begin
      failures++; $display("FAIL srl out=%h required 280343FC", out);
    end
  endtask

  task automatic test_compare;
    issue(rtype(6'h2A), 32'hA00D0FF0, 32'h0FB7AFF0, 5'd0);
    checks++;
    if (out !== 32'h1 || zero !== 1'b0) begin
      failures++; $display("FAIL slt out=%h zero=%b required 1/0", out, zero);
    end
    issue(rtype(6'h2B), 32'hA00D0FF0, 32'h0FB7AFF0, 5'd0);
    checks++;
    if (out !== 32'h0 || zero !== 1'b1) begin
      failures++; $display("FAIL sltu out=%h zero=%b required 0/1", out, zero);
    end
  endtask

  task automatic test_itype;
    issue(itype(6'h09, 16'hFFFF), 32'h00000010, 32'hDEADBEEF, 5'd0);
    checks++;
    if (out !== 32'h0000000F) begin
      failures++; $display("FAIL addiu out=%h required 0000000F", out);
    end
    issue(itype(6'h23, 16'h8000), 32'h00001000, 32'h0, 5'd0);
    checks++;
    if (out !== 32'hFFFF9000) begin
      failures++; $display("FAIL lw_addr out=%h required FFFF9000", out);
    end
    issue(itype(6'h0C, 16'h8001), 32'hFFFFFFFF, 32'h0, 5'd0);
    checks++;
    if (out !== 32'h00008001) begin
      failures++; $display("FAIL andi out=%h required 00008001", out);
    end
    issue(itype(6'h04, 16'h0004), 32'h12345678, 32'h12345678, 5'd0);
    checks++;
    if (out !== 32'h0 || zero !== 1'b1) begin
      failures++; $display("FAIL beq out=%h zero=%b required 0/1", out, zero);
    end
    issue(itype(6'h05, 16'h0004), 32'h1, 32'h2, 5'd0);
    checks++;
    if (out !== 32'hFFFFFFFF || zero !== 1'b0) begin
      failures++; $display("FAIL bne out=%h zero=%b required FFFFFFFF/0", out, zero);
    end
  endtask

  task automatic test_unknown;
    issue(itype(6'h3F, 16'h1234), 32'h5, 32'h6, 5'd0);
    checks++;
    if (out !== 32'h0 || zero !== 1'b1 || valid_out !== 1'b1) begin
      failures++; $display("FAIL bad_opcode out=%h zero=%b valid=%b required 0/1/1", out, zero, valid_out);
    end
    issue(rtype(6'h3F), 32'h5, 32'h6, 5'd0);
    checks++;
    if (out !== 32'h0 || zero !== 1'b1 || hi_out !== 32'h0 || lo_out !== 32'h0) begin
      failures++; $display("FAIL bad_funct out=%h zero=%b hi=%h lo=%h required 0/1/0/0", out, zero, hi_out, lo_out);
    end
  endtask

  task automatic test_multu;
    int low;
    int pulses;
    issue(rtype(6'h19), 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
    // Busy-period request with different operands must be ignored.
    ins_in = rtype(6'h21); a_in = 32'h11111111; b_in = 32'h22222222; valid_in = 1'b1;
    low = 0; pulses = 0;
    while (ready_out !== 1'b1 && low < 100) begin
      low++;
      @(posedge clk); #1;
      if (valid_out === 1'b1) pulses++;
    end
    valid_in = 1'b0;
    checks++;
    if (low !== 32) begin
      failures++; $display("FAIL multu_busy_cycles got=%0d required 32", low);
    end
    checks++;
    if (pulses !== 1 || valid_out !== 1'b1) begin
      failures++; $display("FAIL multu_pulse count=%0d valid=%b required 1/1", pulses, valid_out);
    end
    checks++;
    if (hi_out !== 32'hFFFFFFFE || lo_out !== 32'h1 || out !== 32'h1 || zero !== 1'b0) begin
      failures++;
      $display("FAIL multu_result hi=%h lo=%h out=%h zero=%b required FFFFFFFE/1/1/0", hi_out, lo_out, out, zero);
    end
    issue(rtype(6'h12), 32'h0, 32'h0, 5'd0);
    checks++;
    if (out !== 32'h1 || valid_out !== 1'b1) begin
      failures++; $display("FAIL mflo out=%h valid=%b required 1/1", out, valid_out);
    end
    issue(rtype(6'h10), 32'h0, 32'h0, 5'd0);
    checks++;
    if (out !== 32'hFFFFFFFE) begin
      failures++; $display("FAIL mfhi out=%h required FFFFFFFE", out);
    end
  endtask

  task automatic test_reset_mid_mul;
    int low;
    issue(rtype(6'h19), 32'h00010000, 32'h00010000, 5'd0);
    repeat (10) @(posedge clk);
    #1;
    // Reset arrives between edges, with a fresh request held alongside it.
    ins_in = rtype(6'h19); valid_in = 1'b1; rst = 1'b1;
    #1;
    checks++;
    if (out !== 32'h0 || hi_out !== 32'h0 || lo_out !== 32'h0 || zero !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_regs out=%h hi=%h lo=%h zero=%b required 0/0/0/0", out, hi_out, lo_out, zero);
    end
    checks++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
      failures++; $display("FAIL rst_mid_flags ready=%b valid=%b required 1/0", ready_out, valid_out);
    end
    @(posedge clk); #1;
    valid_in = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
      failures++; $display("FAIL rst_after_edge valid=%b ready=%b required 0/1", valid_out, ready_out);
    end
    issue(rtype(6'h19), 32'h00010000, 32'h00010000, 5'd0);
    low = 0;
    while (ready_out !== 1'b1 && low < 100) begin
      low++;
      @(posedge clk); #1;
    end
    checks++;
    if (low !== 32 || hi_out !== 32'h1 || lo_out !== 32'h0 || out !== 32'h0 || zero !== 1'b1) begin
      failures++;
      $display("FAIL remultu cycles=%0d hi=%h lo=%h out=%h zero=%b required 32/1/0/0/1",
               low, hi_out, lo_out, out, zero);
    end
  endtask

  task automatic test_width16;
    int low;
    ins16 = rtype(6'h21); a16 = 16'hFFFF; b16 = 16'h0001; valid_in16 = 1'b1;
    @(posedge clk); #1;
    valid_in16 = 1'b0;
    checks++;
    if (out16 !== 16'h0000 || zero16 !== 1'b1 || valid16 !== 1'b1) begin
      failures++; $display("FAIL w16_addu out=%h zero=%b valid=%b required 0000/1/1", out16, zero16, valid16);
    end
    ins16 = rtype(6'h19); a16 = 16'hFFFF; b16 = 16'hFFFF; valid_in16 = 1'b1;
    @(posedge clk); #1;
    valid_in16 = 1'b0;
    low = 0;
    while (ready16 !== 1'b1 && low < 100) begin
      low++;
      @(posedge clk); #1;
    end
    checks++;
    if (low !== 16 || hi16 !== 16'hFFFE || lo16 !== 16'h0001 || valid16 !== 1'b1) begin
      failures++;
      $display("FAIL w16_multu cycles=%0d hi=%h lo=%h valid=%b required 16/FFFE/0001/1", low, hi16, lo16, valid16);
    end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_logic;
    test_shifts;
    test_compare;
    test_itype;
    test_unknown;
    test_multu;
    test_reset_mid_mul;
    test_width16;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/z_alu_mc.md
# z_alu_mc

Multi-cycle, width-parametrised ALU for the CSE320 MIPS datapath. It extends the combinational single-cycle ALU operation set with arithmetic shift, signed and unsigned set-less-than, and an iterative unsigned multiply into HI/LO registers. The block sits in the execute stage behind a valid/ready handshake. Results are registered, so the control unit stalls on `ready_out` while a multiply is in progress.

## Interface
- `WIDTH`, default 32: datapath width. Must be 16 or more.
- `SHAMT_W`, default 5: shift-amount width. Must equal clog2(WIDTH).
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `valid_in` in 1: operation request. Sampled only when `ready_out`=1.
- `ready_out` out 1: block idle and able to accept. Combinational from state (IDLE).
- `a_in` in WIDTH: operand A (rs).
- `b_in` in WIDTH: operand B (rt).
- `shamt_in` in SHAMT_W: shift amount for sll/srl/sra.
- `ins_in` in 32: instruction word. opcode = [31:26], funct = [5:0], imm = [15:0].
- `out` out WIDTH: registered result.
- `zero` out 1: registered, equals (`out`==0) for the same result.
- `valid_out` out 1: one-cycle pulse when `out`/`zero` update.
- `hi_out`, `lo_out` out WIDTH: HI/LO multiply registers.

## Operation
- States:
  - IDLE: `ready_out`=1.
  - MUL: `ready_out`=0, iteration counter 0..WIDTH-1.
- R-type ops (opcode 0), all single-cycle, by funct:
  - 0x21 addu: a+b.
  - 0x23 subu: a-b.
  - 0x24 and, 0x25 or, 0x27 nor.
  - 0x00 sll: b<<shamt.
  - 0x02 srl: b>>shamt (logical).
  - 0x03 sra: b>>>shamt (sign fill).
  - 0x2A slt: signed a<b → 1, else 0.
  - 0x2B sltu: unsigned compare.
  - 0x10 mfhi: HI.
  - 0x12 mflo: LO.
  - 0x19 multu: multi-cycle, see below.
- I-type ops, all single-cycle. The immediate comes from `ins_in[15:0]`; `b_in` is ignored except for beq/bne.
  - 0x09 addiu, 0x23 lw, 0x2B sw: a + sign-extended imm.
  - 0x0C andi: a & zero-extended imm.
  - 0x04 beq, 0x05 bne: a-b. The branch unit uses `zero`.
- Unknown opcode or funct: `out`=0, `zero`=1, `valid_out` still pulses. HI/LO unchanged.
- Arithmetic wraps modulo 2^WIDTH. There is no overflow trap.
- multu:
  - The accept edge latches a and b into internal registers and clears a 2*WIDTH accumulator. State goes to MUL.
  - Each MUL cycle shift-adds one multiplier bit, LSB first.
  - After WIDTH iterations, HI = product[2W-1:W] and LO = product[W-1:0].
  - On that same edge `out` = LO, `zero` = (LO==0), and `valid_out` pulses. State returns to IDLE.
- `valid_in` while `ready_out`=0 is ignored: not queued and not acknowledged.
- Inputs are sampled only on the accept edge. Changes to inputs during MUL have no effect.

## Timing
- Reset values:
  - `out`, `hi_out`, `lo_out` = 0.
  - `zero` = 0, `valid_out` = 0.
  - State IDLE, so `ready_out` = 1.
  - Counter = 0.
- Single-cycle op accepted at edge N:
  - `out`, `zero` and `valid_out`=1 are visible after edge N, for one cycle.
  - `ready_out` stays 1, so back-to-back accepts occur every cycle.
- multu accepted at edge N:
  - `ready_out`=0 after edge N.
  - Iterations run on edges N+1 .. N+WIDTH.
  - HI/LO/`out` update and `valid_out`=1 after edge N+WIDTH.
  - `ready_out`=1 after edge N+WIDTH, so the next accept is at edge N+WIDTH+1.
- `valid_out` is 0 on every cycle without a completion.
- mfhi/mflo accepted at edge N+WIDTH+1 returns the new HI/LO.
- `rst` mid-multiply:
  - Immediate abort. All registers go to their reset values.
  - No `valid_out` pulse, on either the reset cycle or the following edge.
- `rst` asserted together with `valid_in`: reset wins and the request is dropped.

## Test plan
- a=0x0FB7AFF0, b=0xA00D0FF0:
  - addu → `out`=0xAFC4BFE0, `zero`=0.
  - subu → 0x6FAAA000.
  - `valid_out` pulses one cycle after each accept, with the two ops issued on consecutive cycles.
- sll with b=0x0FB7AFF0, shamt=2 → 0x3EDEBFC0.
- sra with b=0xA00D0FF0, shamt=2 → 0xE80343FC.
- srl with the same b and shamt → 0x280343FC.
- slt/sltu with a=0xA00D0FF0, b=0x0FB7AFF0:
  - slt → 1.
  - sltu → 0.
- beq with a=b=0x12345678:
  - `out`=0, `zero`=1.
  - bne with a=1, b=2 gives `out`=0xFFFFFFFF, `zero`=0.
- multu with a=b=0xFFFFFFFF:
  - `ready_out` is low for exactly 32 cycles.
  - Then HI=0xFFFFFFFE, LO=`out`=0x00000001, with a single `valid_out` pulse.
  - An addu request during the busy period is ignored.
  - mflo issued next → 0x00000001.
- Reset mid-multiply:
  - Start multu with a=b=0x00010000 and assert `rst` at iteration 10.
  - All outputs go to 0 immediately, `ready_out`=1, no `valid_out`.
  - A re-issued multu yields HI=0x1, LO=0. Then WIDTH=16 regression: addu 0xFFFF+0x0001 → 0x0000 with `zero`=1.
